player_damage_ctrl: RTL and testbench
=====================================

// Module: player_damage_ctrl
// PURPOSE
//  Sequences damage for both players: arbitrates collision hits, decrements lives and times the
//  post-hit protection window. It also drives the blink/invert and invulnerable flags to the
//  player drawing blocks, and declares game over and the winner. It sits between the collision
//  matrix and the player draw/move logic. The timebase is the shared turbo_pulse tick.
// PARAMETERS
//  LIVES_INIT   3   lives loaded at reset and on start_game
//  LIFE_W       2   width of lives counters; LIVES_INIT must fit in LIFE_W
//  PROT_PULSES  10  protection length after a hit, in turbo_pulse ticks (>=1, <=31)
// PORTS
//  clk              in   1       system clock
//  resetN           in   1       async active-low reset
//  start_game       in   1       1-cycle pulse: reload lives, enter play
//  turbo_pulse      in   1       1-cycle timebase tick
//  hit_p1           in   1       player1 collision with blast; level, may last many cycles
//  hit_p2           in   1       player2 collision with blast; level
//  p1_lives         out  LIFE_W  remaining lives, player1
//  p2_lives         out  LIFE_W  remaining lives, player2
//  p1_blink         out  1       1 = draw player1 inverted
//  p2_blink         out  1       1 = draw player2 inverted
//  p1_invulnerable  out  1       player1 is ignoring hits
//  p2_invulnerable  out  1       player2 is ignoring hits
//  game_over        out  1       game finished
//  winner           out  2       00 none, 01 p1, 10 p2, 11 draw
// BEHAVIOUR
//  - All outputs are registered. A response appears on the clock edge that samples the input
//    (visible the next cycle).
//  - Reset (any time, including mid-protection): game SM=IDLE, both player SMs=VULN,
//    lives=LIVES_INIT, prot counters=0, blink=0, invulnerable=0, game_over=0, winner=00.
//  - Game SM states: IDLE, PLAY, OVER.
//      IDLE -> PLAY on start_game.
//      PLAY -> OVER when any lives counter reaches 0.
//      OVER -> PLAY on start_game.
//  - start_game in any state reloads lives, zeroes counters and sets player SMs to VULN.
//    It clears blink, invulnerable, game_over and winner. It has priority over hits in the
//    same cycle.
//  - Hits are ignored in IDLE and OVER.
//  - Per-player SM states: VULN, PROT, DEAD (p1 and p2 are independent, identical).
//      VULN with hit in PLAY: accept the hit. Lives decrement by 1. If the result is 0 ->
//      DEAD, otherwise -> PROT with cnt=0, blink=1, invulnerable=1.
//      PROT: the hit input is ignored. On each turbo_pulse, cnt is incremented and blink is
//      toggled. On the pulse where cnt==PROT_PULSES-1 -> VULN with blink=0, invulnerable=0,
//      cnt=0. A held hit is re-accepted only after returning to VULN.
//      DEAD: blink=0, invulnerable=1. Left only by start_game or reset.
//  - turbo_pulse on the same cycle as a hit is accepted: the hit takes effect and the pulse is
//    not counted.
//  - Lives never wrap: a decrement from 0 is impossible because that player is DEAD.
//  - Game over is registered on the same edge a lives counter reaches 0:
//      only p1 at 0 -> winner=10
//      only p2 at 0 -> winner=01
//      both reach 0 on the same edge -> winner=11
//  - In OVER: lives and winner are frozen, and both blink outputs=0. The surviving player
//    finishes protection timing but cannot take hits.
//  - Both players hit in the same cycle: both hits are accepted. There is no arbitration loss.
// TESTING
//  1. Reset, start_game, then hit_p1 for 1 cycle -> next cycle p1_lives=2, p1_blink=1,
//     p1_invulnerable=1. p2 outputs are unchanged (lives=3, flags 0).
//  2. Hold hit_p1 high for 12 turbo_pulses -> exactly one decrement during protection.
//     blink toggles on each pulse. invulnerable drops after the 10th pulse. Lives go to 1 on
//     the next cycle because the hit is still held.
//  3. Three spaced hits to p2 -> p2_lives=0, game_over=1 and winner=01 on the same edge.
//     Further hit_p1 is ignored (p1_lives stays 3).
//  4. Both players at 1 life, hit_p1 and hit_p2 in the same cycle -> both lives=0,
//     game_over=1, winner=11.
//  5. start_game in the same cycle as hit_p1 -> lives=3/3, no decrement, flags 0. Then
//     resetN low mid-protection -> all outputs return to reset values asynchronously.
//  6. Hits in IDLE (before start_game) -> no change to lives or flags.

Source files
------------

// File: rtl/player_damage_ctrl.sv
// -----------------------------------------------------------------------------
// player_damage_ctrl
//   Damage sequencer for a two-player game. Accepts collision hits while the
//   game is running, decrements lives, times the post-hit protection window on
//   the shared turbo_pulse tick, drives the blink / invulnerable flags to the
//   player draw logic, and declares game over and the winner.
//
// Ports
//   clk              in   1       system clock
//   resetN           in   1       async active-low reset
//   start_game       in   1       1-cycle pulse: reload lives, enter play
//   turbo_pulse      in   1       1-cycle timebase tick
//   hit_p1 / hit_p2  in   1       collision levels (may be held many cycles)
//   p1_lives/p2_lives out LIFE_W  remaining lives
//   p1_blink/p2_blink out 1       draw player inverted
//   p1_invulnerable/p2_invulnerable out 1  player ignores hits
//   game_over        out  1       game finished
//   winner           out  2       00 none, 01 p1, 10 p2, 11 draw
//
// All outputs come straight from registers.
// -----------------------------------------------------------------------------
module player_damage_ctrl #(
  parameter int LIVES_INIT  = 3,
  parameter int LIFE_W      = 2,
  parameter int PROT_PULSES = 10
) (
  input  logic              clk,
  input  logic              resetN,
  input  logic              start_game,
  input  logic              turbo_pulse,
  input  logic              hit_p1,
  input  logic              hit_p2,
  output logic [LIFE_W-1:0] p1_lives,
  output logic [LIFE_W-1:0] p2_lives,
  output logic              p1_blink,
  output logic              p2_blink,
  output logic              p1_invulnerable,
  output logic              p2_invulnerable,
  output logic              game_over,
  output logic [1:0]        winner
);

  localparam int CNT_W = 5;  // PROT_PULSES is at most 31

  localparam logic [LIFE_W-1:0] LIVES_LOAD = LIFE_W'(LIVES_INIT);
  localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(PROT_PULSES - 1);

  typedef enum logic [1:0] {
    G_IDLE,
    G_PLAY,
    G_OVER
  } game_state_t;

  typedef enum logic [1:0] {
    P_VULN,
    P_PROT,
    P_DEAD
  } plr_state_t;

  // Index 0 is player1, index 1 is player2.
  game_state_t       r_game_state, w_game_state;
  plr_state_t        r_plr_state  [2];
  plr_state_t        w_plr_state  [2];
  logic [CNT_W-1:0]  r_cnt        [2];
  logic [CNT_W-1:0]  w_cnt        [2];
  logic [LIFE_W-1:0] r_lives      [2];
  logic [LIFE_W-1:0] w_lives      [2];
  logic              r_blink      [2];
  logic              w_blink      [2];
  logic              r_inv        [2];
  logic              w_inv        [2];
  logic              r_game_over, w_game_over;
  logic [1:0]        r_winner,    w_winner;

  logic              w_hit        [2];
  logic              w_zero       [2];

  assign w_hit[0] = hit_p1;
  assign w_hit[1] = hit_p2;

  // ---------------------------------------------------------------------------
  // Next-state logic for the game SM and both player SMs.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default before any branch so no path leaves it
    // unassigned; otherwise synthesis would infer a latch to hold the old value.
    w_game_state = r_game_state;
    w_game_over  = r_game_over;
    w_winner     = r_winner;
    for (int i = 0; i < 2; i++) begin
      w_plr_state[i] = r_plr_state[i];
      w_cnt[i]       = r_cnt[i];
      w_lives[i]     = r_lives[i];
      w_blink[i]     = r_blink[i];
      w_inv[i]       = r_inv[i];
      w_zero[i]      = 1'b0;
    end

    if (start_game) begin
      // A new game overrides anything else happening this cycle, hits included.
      w_game_state = G_PLAY;
      w_game_over  = 1'b0;
      w_winner     = 2'b00;
      for (int i = 0; i < 2; i++) begin
        w_plr_state[i] = P_VULN;
        w_cnt[i]       = '0;
        w_lives[i]     = LIVES_LOAD;
        w_blink[i]     = 1'b0;
        w_inv[i]       = 1'b0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        unique case (r_plr_state[i])
          P_VULN: begin
            // A tick arriving with the hit is simply not counted: VULN ignores it.
            if (r_game_state == G_PLAY && w_hit[i]) begin
              w_lives[i] = r_lives[i] - LIFE_W'(1);
              w_cnt[i]   = '0;
              w_inv[i]   = 1'b1;
              if (r_lives[i] == LIFE_W'(1)) begin
                w_plr_state[i] = P_DEAD;
                w_blink[i]     = 1'b0;
              end else begin
                w_plr_state[i] = P_PROT;
                w_blink[i]     = 1'b1;
              end
            end
          end
          P_PROT: begin
            // Protection keeps timing even after game over so the survivor's
            // invulnerable flag still drops at the right moment.
            if (turbo_pulse) begin
              if (r_cnt[i] == CNT_LAST) begin
                w_plr_state[i] = P_VULN;
                w_cnt[i]       = '0;
                w_blink[i]     = 1'b0;
                w_inv[i]       = 1'b0;
              end else begin
                w_cnt[i]   = r_cnt[i] + CNT_W'(1);
                w_blink[i] = ~r_blink[i];
              end
            end
          end
          P_DEAD: begin
            w_blink[i] = 1'b0;
            w_inv[i]   = 1'b1;
          end
          default: begin
            w_plr_state[i] = P_VULN;
          end
        endcase
        w_zero[i] = (w_lives[i] == '0);
      end

      if (r_game_state == G_PLAY && (w_zero[0] || w_zero[1])) begin
        // Winner bits are {p1 out, p2 out}: p1 out -> p2 wins (10), and so on.
        w_game_state = G_OVER;
        w_game_over  = 1'b1;
        w_winner     = {w_zero[0], w_zero[1]};
      end

      // Nobody blinks once the game has ended, from the ending edge onward.
      if (w_game_state == G_OVER) begin
        w_blink[0] = 1'b0;
        w_blink[1] = 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State registers.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetN) begin
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // the pre-edge values and simulation matches the synthesized flops.
    if (!resetN) begin
      r_game_state <= G_IDLE;
      r_game_over  <= 1'b0;
      r_winner     <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        r_plr_state[i] <= P_VULN;
        r_cnt[i]       <= '0;
        r_lives[i]     <= LIVES_LOAD;
        r_blink[i]     <= 1'b0;
        r_inv[i]       <= 1'b0;
      end
    end else begin
      r_game_state <= w_game_state;
      r_game_over  <= w_game_over;
      r_winner     <= w_winner;
      for (int i = 0; i < 2; i++) begin
        r_plr_state[i] <= w_plr_state[i];
        r_cnt[i]       <= w_cnt[i];
        r_lives[i]     <= w_lives[i];
        r_blink[i]     <= w_blink[i];
        r_inv[i]       <= w_inv[i];
      end
    end
  end

  assign p1_lives        = r_lives[0];
  assign p2_lives        = r_lives[1];
  assign p1_blink        = r_blink[0];
  assign p2_blink        = r_blink[1];
  assign p1_invulnerable = r_inv[0];
  assign p2_invulnerable = r_inv[1];
  assign game_over       = r_game_over;
  assign winner          = r_winner;

endmodule

// File: tb/tb_player_damage_ctrl.sv
// -----------------------------------------------------------------------------
// tb_player_damage_ctrl
//   Directed bench for player_damage_ctrl (LIVES_INIT=3, LIFE_W=2,
//   PROT_PULSES=10). Inputs change 1 ns after the rising edge and outputs are
//   compared there, well away from the active edge.
// -----------------------------------------------------------------------------
module tb_player_damage_ctrl;

  logic       clk = 1'b0;
  logic       resetN;
  logic       start_game;
  logic       turbo_pulse;
  logic       hit_p1;
  logic       hit_p2;
  logic [1:0] p1_lives;
  logic [1:0] p2_lives;
  logic       p1_blink;
  logic       p2_blink;
  logic       p1_invulnerable;
  logic       p2_invulnerable;
  logic       game_over;
  logic [1:0] winner;

  int n_checks = 0;
  int n_errors = 0;

  player_damage_ctrl #(
    .LIVES_INIT (3),
    .LIFE_W     (2),
    .PROT_PULSES(10)
  ) dut (
    .clk            (clk),
    .resetN         (resetN),
    .start_game     (start_game),
    .turbo_pulse    (turbo_pulse),
    .hit_p1         (hit_p1),
    .hit_p2         (hit_p2),
    .p1_lives       (p1_lives),
    .p2_lives       (p2_lives),
    .p1_blink       (p1_blink),
    .p2_blink       (p2_blink),
    .p1_invulnerable(p1_invulnerable),
    .p2_invulnerable(p2_invulnerable),
    .game_over      (game_over),
    .winner         (winner)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance one clock: return 1 ns after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start();
    start_game = 1'b1;
    step();
    start_game = 1'b0;
  endtask

  task automatic hit(input logic h1, input logic h2);
    hit_p1 = h1;
    hit_p2 = h2;
    step();
    hit_p1 = 1'b0;
    hit_p2 = 1'b0;
  endtask

  // n turbo ticks, each followed by an idle cycle.
  task automatic pulses(input int n);
    for (int k = 0; k < n; k++) begin
      turbo_pulse = 1'b1;
      step();
      turbo_pulse = 1'b0;
      step();
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_p1_lives"}, p1_lives, 3);
    check({tag, "_p2_lives"}, p2_lives, 3);
    check({tag, "_p1_blink"}, p1_blink, 0);
    check({tag, "_p2_blink"}, p2_blink, 0);
    check({tag, "_p1_inv"}, p1_invulnerable, 0);
    check({tag, "_p2_inv"}, p2_invulnerable, 0);
    check({tag, "_game_over"}, game_over, 0);
    check({tag, "_winner"}, winner, 0);
  endtask

  initial begin
    resetN      = 1'b0;
    start_game  = 1'b0;
    turbo_pulse = 1'b0;
    hit_p1      = 1'b0;
    hit_p2      = 1'b0;
    #12;
    check_reset_values("rst");
    resetN = 1'b1;
    step();

    // Hits before start_game are ignored.
    hit(1'b1, 1'b1);
    hit(1'b1, 1'b1);
    check("idle_p1_lives", p1_lives, 3);
    check("idle_p2_lives", p2_lives, 3);
    check("idle_p1_inv", p1_invulnerable, 0);
    check("idle_p1_blink", p1_blink, 0);

    // Single hit to p1.
    start();
    hit(1'b1, 1'b0);
    check("t1_p1_lives", p1_lives, 2);
    check("t1_p1_blink", p1_blink, 1);
    check("t1_p1_inv", p1_invulnerable, 1);
    check("t1_p2_lives", p2_lives, 3);
    check("t1_p2_blink", p2_blink, 0);
    check("t1_p2_inv", p2_invulnerable, 0);
    pulses(1);
    check("t1_blink_p1", p1_blink, 0);
    pulses(1);
    check("t1_blink_p2", p1_blink, 1);
    pulses(7);
    check("t1_inv_p9", p1_invulnerable, 1);
    check("t1_blink_p9", p1_blink, 0);
    pulses(1);
    check("t1_inv_p10", p1_invulnerable, 0);
    check("t1_blink_p10", p1_blink, 0);
    check("t1_lives_end", p1_lives, 2);

    // Held hit: one decrement per protection window.
    start();
    check("t2_reload", p1_lives, 3);
    hit_p1 = 1'b1;
    step();
    check("t2_lives_a", p1_lives, 2);
    for (int k = 1; k <= 9; k++) begin
      turbo_pulse = 1'b1;
      step();
      turbo_pulse = 1'b0;
      step();
      if (k <= 2) check($sformatf("t2_blink_p%0d", k), p1_blink, (k % 2 == 0) ? 1 : 0);
    end
    check("t2_lives_p9", p1_lives, 2);
    check("t2_inv_p9", p1_invulnerable, 1);
    turbo_pulse = 1'b1;
    step();
    turbo_pulse = 1'b0;
    check("t2_inv_p10", p1_invulnerable, 0);
    check("t2_blink_p10", p1_blink, 0);
    check("t2_lives_p10", p1_lives, 2);
    step();
    check("t2_lives_b", p1_lives, 1);
    check("t2_inv_b", p1_invulnerable, 1);
    check("t2_blink_b", p1_blink, 1);
    hit_p1 = 1'b0;

    // Three spaced hits knock out p2: p1 wins.
    start();
    check_reset_values("t3_start");
    hit(1'b0, 1'b1);
    check("t3_p2_lives_a", p2_lives, 2);
    pulses(10);
    hit(1'b0, 1'b1);
    check("t3_p2_lives_b", p2_lives, 1);
    pulses(10);
    check("t3_go_before", game_over, 0);
    hit(1'b0, 1'b1);
    check("t3_p2_lives_c", p2_lives, 0);
    check("t3_game_over", game_over, 1);
    check("t3_winner", winner, 2'b01);
    check("t3_p2_inv", p2_invulnerable, 1);
    check("t3_p2_blink", p2_blink, 0);
    hit(1'b1, 1'b0);
    check("t3_p1_ignored", p1_lives, 3);
    check("t3_p1_inv", p1_invulnerable, 0);
    check("t3_winner_frozen", winner, 2'b01);

    // Game ends while p1 is protected: blink off, protection still times out.
    start();
    hit(1'b0, 1'b1);
    pulses(10);
    hit(1'b0, 1'b1);
    pulses(10);
    hit(1'b1, 1'b0);
    check("t3b_p1_blink_on", p1_blink, 1);
    hit(1'b0, 1'b1);
    check("t3b_game_over", game_over, 1);
    check("t3b_winner", winner, 2'b01);
    check("t3b_p1_blink_off", p1_blink, 0);
    check("t3b_p1_inv_kept", p1_invulnerable, 1);
    pulses(1);
    check("t3b_p1_blink_p1", p1_blink, 0);
    pulses(9);
    check("t3b_p1_inv_done", p1_invulnerable, 0);
    hit(1'b1, 1'b0);
    check("t3b_p1_lives", p1_lives, 2);

    // Simultaneous final hits: draw.
    start();
    hit(1'b1, 1'b1);
    pulses(10);
    hit(1'b1, 1'b1);
    pulses(10);
    check("t4_p1_lives_1", p1_lives, 1);
    check("t4_p2_lives_1", p2_lives, 1);
    hit(1'b1, 1'b1);
    check("t4_p1_lives_0", p1_lives, 0);
    check("t4_p2_lives_0", p2_lives, 0);
    check("t4_game_over", game_over, 1);
    check("t4_winner", winner, 2'b11);

    // start_game beats a same-cycle hit.
    start_game = 1'b1;
    hit_p1     = 1'b1;
    step();
    start_game = 1'b0;
    hit_p1     = 1'b0;
    check_reset_values("t5_start");

    // Tick coinciding with a hit is not counted.
    turbo_pulse = 1'b1;
    hit_p1      = 1'b1;
    step();
    turbo_pulse = 1'b0;
    hit_p1      = 1'b0;
    check("t5_lives", p1_lives, 2);
    check("t5_blink", p1_blink, 1);
    pulses(9);
    check("t5_inv_p9", p1_invulnerable, 1);

    // Asynchronous reset mid-protection.
    #2;
    resetN = 1'b0;
    #1;
    check_reset_values("t5_rst");
    #10;
    resetN = 1'b1;
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
